// File: rtl/w5500_spi_frame.sv
// W5500 variable-length-data-mode SPI frame engine: 16-bit address, control byte,
// then length data bytes, with write data pulled via o_rdreq and read data on o_den/o_dout.
module w5500_spi_frame #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [15:0] addr,
  input  logic [15:0] length,
  input  logic [7:0]  dat,
  output logic        o_rdreq,
  output logic        o_wrend,
  output logic        o_den,
  output logic [7:0]  o_dout,
  output logic        o_busy,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned CW = 16;

  typedef enum logic [3:0] {
    IDLE, SETUP, HDR, BREQ, BWAIT, BLAT, DATA, HOLD, DONE, GAP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0]    bitcnt;
  logic [23:0]   shreg;
  logic [7:0]    rx;
  logic [15:0]   rem;
  logic          rwb;
  logic          den_pend;

  logic shifting_c, half_end_c, rise_c, fall_c;
  logic cs_n_d, sclk_d, rdreq_d, wrend_d, busy_d;

  assign shifting_c = (state == HDR) || (state == DATA);
  assign half_end_c = (cnt == CW'(CLK_DIV - 1));
  assign rise_c     = shifting_c && !spi_sclk && half_end_c;
  assign fall_c     = shifting_c &&  spi_sclk && half_end_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: if (cnt == CW'(CS_SETUP - 1)) state_nxt = HDR;
      HDR:   if (fall_c && bitcnt == 5'd23) state_nxt = (rem == 16'd0) ? HOLD : BREQ;
      BREQ:  state_nxt = BWAIT;
      BWAIT: state_nxt = BLAT;
      BLAT:  state_nxt = DATA;
      DATA:  if (fall_c && bitcnt == 5'd7) state_nxt = (rem <= 16'd1) ? HOLD : BREQ;
      // Trailing cycles keep o_wrend at least CS_HOLD+3 cycles behind the last o_den
      HOLD:  if (cnt == CW'(CS_HOLD + 2)) state_nxt = DONE;
      DONE:  state_nxt = GAP;
      GAP:   if (cnt == CW'(CS_IDLE - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered control outputs
  always_comb begin
    cs_n_d  = (state_nxt == IDLE) || (state_nxt == DONE) || (state_nxt == GAP) ||
              (state == HOLD && cnt >= CW'(CS_HOLD - 1));
    sclk_d  = shifting_c && (spi_sclk ^ half_end_c);
    rdreq_d = (state_nxt == BREQ) && rwb;
    wrend_d = (state_nxt == DONE);
    busy_d  = !((state_nxt == IDLE) || (state_nxt == GAP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      o_rdreq  <= 1'b0;
      o_wrend  <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      spi_cs_n <= cs_n_d;
      spi_sclk <= sclk_d;
      o_rdreq  <= rdreq_d;
      o_wrend  <= wrend_d;
      o_busy   <= busy_d;
    end
  end

  // Counters, shift registers and read-byte return path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      rx       <= '0;
      rem      <= '0;
      rwb      <= 1'b0;
      den_pend <= 1'b0;
      spi_mosi <= 1'b0;
      o_den    <= 1'b0;
      o_dout   <= '0;
    end else begin
      if (state_nxt != state || state == IDLE || (shifting_c && half_end_c))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      if (state_nxt != state) bitcnt <= '0;
      else if (fall_c)        bitcnt <= bitcnt + 5'd1;

      if (state == IDLE && start) begin
        shreg    <= {addr, cmd};
        spi_mosi <= addr[15];
        rem      <= length;
        rwb      <= cmd[2];
      end else if (fall_c) begin
        shreg    <= {shreg[22:0], 1'b0};
        spi_mosi <= shreg[22];
      end else if (state == BLAT) begin
        shreg    <= {(rwb ? dat : 8'h00), 16'h0000};
        spi_mosi <= rwb & dat[7];
      end

      if (rise_c) rx <= {rx[6:0], spi_miso};

      if (state == DATA && fall_c && bitcnt == 5'd7)
        rem <= (rem != 16'd0) ? rem - 16'd1 : 16'd0;

      den_pend <= rise_c && (state == DATA) && (bitcnt == 5'd7) && !rwb;
      o_den    <= den_pend;
      if (den_pend) o_dout <= rx;
    end
  end

endmodule
